// File: rtl/dcache_refill_responder.sv
// dcache refill responder: serves one 256-bit line per transaction from the
// line-buffer SRAM. A transaction is either a write-back of a dirty line or a
// read refill. Flow: grant pulse, address handshake, then an SRAM write or an
// SRAM read whose data is returned as a single rvalid pulse.
module dcache_refill_responder #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 256,
    parameter int RD_LAT = 1,   // SRAM read latency, 1..4
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dcache_refill_req,
    output logic              dcache_refill_gnt,
    input  logic              dcache_refill_we,
    input  logic [ADDR_W-1:0] dcache_refill_addr,
    input  logic              dcache_refill_addr_valid,
    output logic              dcache_refill_addr_ready,
    input  logic              dcache_refill_wvalid,
    input  logic [DATA_W-1:0] dcache_refill_wdata,
    output logic              dcache_refill_rvalid,
    output logic [DATA_W-1:0] dcache_refill_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt
);

    // Two bits cover RD_LAT-1 for the full 1..4 latency range.
    localparam int WAIT_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_ADDR,
        S_WDATA,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_rdata;
    logic [WAIT_W-1:0]   r_wait;
    logic [CNT_W-1:0]    r_wr_cnt;
    logic [CNT_W-1:0]    r_rd_cnt;

    logic                w_addr_hs;
    logic                w_wr_fire;
    logic                w_rd_cap;

    // addr_ready is purely state-decoded, so the handshake is just valid in ADDR.
    assign w_addr_hs = (r_state == S_ADDR) && dcache_refill_addr_valid;
    assign w_wr_fire = (r_state == S_WDATA) && dcache_refill_wvalid;
    // Wait counter reaches zero in the cycle the SRAM read data is valid.
    assign w_rd_cap  = (r_state == S_RD_WAIT) && (r_wait == '0);

    // State register; async reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and state-decoded control outputs.
    always_comb begin
        w_next                   = r_state;
        dcache_refill_gnt        = 1'b0;
        dcache_refill_addr_ready = 1'b0;
        dcache_refill_rvalid     = 1'b0;
        mem_cs                   = 1'b0;
        mem_we                   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dcache_refill_req) w_next = S_GRANT;
            end
            S_GRANT: begin
                dcache_refill_gnt = 1'b1;
                w_next            = S_ADDR;
            end
            S_ADDR: begin
                dcache_refill_addr_ready = 1'b1;
                if (dcache_refill_addr_valid) w_next = r_we ? S_WDATA : S_RD_ISSUE;
                else if (!dcache_refill_req)  w_next = S_IDLE;
            end
            S_WDATA: begin
                // Write fires combinationally in the cycle wvalid is seen.
                if (dcache_refill_wvalid) begin
                    mem_cs = 1'b1;
                    mem_we = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_RD_ISSUE: begin
                mem_cs = 1'b1;
                w_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (r_wait == '0) w_next = S_RESP;
            end
            S_RESP: begin
                dcache_refill_rvalid = 1'b1;
                w_next               = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Transaction latches, read-latency countdown, refill data and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_rdata  <= '0;
            r_wait   <= '0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if ((r_state == S_IDLE) && dcache_refill_req) r_we <= dcache_refill_we;
            if (w_addr_hs) r_addr <= dcache_refill_addr;
            if (r_state == S_RD_ISSUE)
                r_wait <= WAIT_W'(RD_LAT - 1);
            else if ((r_state == S_RD_WAIT) && (r_wait != '0))
                r_wait <= r_wait - WAIT_W'(1);
            if (w_rd_cap) r_rdata <= mem_rdata;
            if (w_wr_fire) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            if (r_state == S_RESP) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
        end
    end

    // Address always comes from the latch; write data only passes in WDATA.
    assign mem_addr            = r_addr;
    assign mem_wdata           = (r_state == S_WDATA) ? dcache_refill_wdata : '0;
    assign dcache_refill_rdata = r_rdata;
    assign busy                = (r_state != S_IDLE);
    assign wr_cnt              = r_wr_cnt;
    assign rd_cnt              = r_rd_cnt;

endmodule

// File: tb/tb_dcache_refill_responder.sv
// Bench for dcache_refill_responder. Two instances share one SRAM model:
// A (RD_LAT=1, CNT_W=16) and B (RD_LAT=3, CNT_W=3, for quick wrap). sel picks
// the active one; the idle one sees req/addr_valid/wvalid forced low.
module tb_dcache_refill_responder;

    localparam int AW = 12;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sel;
    logic          mem_clr;

    logic          req, we, addr_valid, wvalid;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mem_rdata;

    logic          a_gnt, a_ardy, a_rvalid, a_cs, a_mwe, a_busy;
    logic [DW-1:0] a_rdata, a_mwdata;
    logic [AW-1:0] a_maddr;
    logic [15:0]   a_wr_cnt, a_rd_cnt;
    logic          b_gnt, b_ardy, b_rvalid, b_cs, b_mwe, b_busy;
    logic [DW-1:0] b_rdata, b_mwdata;
    logic [AW-1:0] b_maddr;
    logic [2:0]    b_wr_cnt, b_rd_cnt;

    logic          gnt, addr_ready, rvalid, mem_cs, mem_we, busy;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [15:0]   wr_cnt, rd_cnt;

    int checks   = 0;
    int failures = 0;
    int rw [2];
    int rr [2];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    always #5 clk = ~clk;

    dcache_refill_responder #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .dcache_refill_req(req & ~sel), .dcache_refill_gnt(a_gnt),
        .dcache_refill_we(we), .dcache_refill_addr(addr),
        .dcache_refill_addr_valid(addr_valid & ~sel), .dcache_refill_addr_ready(a_ardy),
        .dcache_refill_wvalid(wvalid & ~sel), .dcache_refill_wdata(wdata),
        .dcache_refill_rvalid(a_rvalid), .dcache_refill_rdata(a_rdata),
        .mem_cs(a_cs), .mem_we(a_mwe), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
        .mem_rdata(mem_rdata), .busy(a_busy), .wr_cnt(a_wr_cnt), .rd_cnt(a_rd_cnt)
    );

    dcache_refill_responder #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .CNT_W(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .dcache_refill_req(req & sel), .dcache_refill_gnt(b_gnt),
        .dcache_refill_we(we), .dcache_refill_addr(addr),
        .dcache_refill_addr_valid(addr_valid & sel), .dcache_refill_addr_ready(b_ardy),
        .dcache_refill_wvalid(wvalid & sel), .dcache_refill_wdata(wdata),
        .dcache_refill_rvalid(b_rvalid), .dcache_refill_rdata(b_rdata),
        .mem_cs(b_cs), .mem_we(b_mwe), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
        .mem_rdata(mem_rdata), .busy(b_busy), .wr_cnt(b_wr_cnt), .rd_cnt(b_rd_cnt)
    );

    assign gnt        = sel ? b_gnt    : a_gnt;
    assign addr_ready = sel ? b_ardy   : a_ardy;
    assign rvalid     = sel ? b_rvalid : a_rvalid;
    assign rdata      = sel ? b_rdata  : a_rdata;
    assign mem_cs     = sel ? b_cs     : a_cs;
    assign mem_we     = sel ? b_mwe    : a_mwe;
    assign mem_addr   = sel ? b_maddr  : a_maddr;
    assign mem_wdata  = sel ? b_mwdata : a_mwdata;
    assign busy       = sel ? b_busy   : a_busy;
    assign wr_cnt     = sel ? {13'd0, b_wr_cnt} : a_wr_cnt;
    assign rd_cnt     = sel ? {13'd0, b_rd_cnt} : a_rd_cnt;

    // Background content of never-written lines.
    function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = 32'(a) * 32'h9E3779B1 + 32'(k) * 32'h01010101;
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_line();
        logic [DW-1:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return 12'h0A0 + 12'($urandom_range(0, 15));
    endfunction

    // SRAM model: latency-pipelined reads; rdata is random junk outside the valid cycle.
    logic [DW-1:0] sram [0:4095];
    logic [4095:0] sram_v;
    logic [DW-1:0] rpipe [0:3];
    logic [3:0]    rpv;
    logic [DW-1:0] junk;
    logic [1:0]    lat_idx;

    always @(posedge clk) begin
        if (mem_clr) sram_v <= '0;
        else if (mem_cs && mem_we) begin
            sram[mem_addr]   <= mem_wdata;
            sram_v[mem_addr] <= 1'b1;
        end
        rpipe[0] <= sram_v[mem_addr] ? sram[mem_addr] : init_pat(mem_addr);
        rpv[0]   <= mem_cs & ~mem_we;
        for (int i = 1; i < 4; i++) begin
            rpipe[i] <= rpipe[i-1];
            rpv[i]   <= rpv[i-1];
        end
        junk <= rnd_line();
    end

    assign lat_idx   = sel ? 2'd2 : 2'd0;
    assign mem_rdata = rpv[lat_idx] ? rpipe[lat_idx] : junk;

    // Reference model helpers.
    function automatic logic [DW-1:0] exp_line(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
    endfunction

    function automatic int cmask();
        return sel ? 7 : 32'hFFFF;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, DW'(obs), DW'(exp));
    endtask

    task automatic chkc(input string tag, input logic [15:0] obs, input int exp);
        chk(tag, DW'(obs), DW'(16'(exp)));
    endtask

    task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        chk(tag, DW'(obs), DW'(exp));
    endtask

    task automatic chk_cnts(input string tag);
        chkc({tag, "_wr_cnt"}, wr_cnt, rw[sel] & cmask());
        chkc({tag, "_rd_cnt"}, rd_cnt, rr[sel] & cmask());
    endtask

    task automatic all_zero(input string tag);
        chk1({tag, "_gnt"}, gnt, 1'b0);
        chk1({tag, "_ardy"}, addr_ready, 1'b0);
        chk1({tag, "_rvalid"}, rvalid, 1'b0);
        chk({tag, "_rdata"}, rdata, '0);
        chk1({tag, "_cs"}, mem_cs, 1'b0);
        chk1({tag, "_mwe"}, mem_we, 1'b0);
        chka({tag, "_maddr"}, mem_addr, '0);
        chk({tag, "_mwdata"}, mem_wdata, '0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chkc({tag, "_wr_cnt"}, wr_cnt, 0);
        chkc({tag, "_rd_cnt"}, rd_cnt, 0);
    endtask

    // One full transaction; entered and left at a negedge with the DUT in IDLE.
    task automatic txn(input logic t_we, input logic [AW-1:0] t_addr, input logic [DW-1:0] t_data,
                       input int a_dly, input int w_dly, input logic hold, input logic spur);
        int lat;
        bit seen;
        lat = sel ? 3 : 1;
        req = 1'b1;
        we  = t_we;
        @(negedge clk);
        chk1("gnt", gnt, 1'b1);
        chk1("ardy_in_grant", addr_ready, 1'b0);
        we = ~t_we;
        if (spur) begin
            addr_valid = 1'b1;
            addr       = ~t_addr;
            wvalid     = 1'b1;
            #1 chk1("cs_spur_grant", mem_cs, 1'b0);
        end
        @(negedge clk);
        chk1("gnt_one_cycle", gnt, 1'b0);
        chk1("ardy", addr_ready, 1'b1);
        addr_valid = 1'b0;
        for (int d = 0; d < a_dly; d++) begin
            #1 chk1("cs_before_hs", mem_cs, 1'b0);
            @(negedge clk);
            chk1("ardy_wait", addr_ready, 1'b1);
        end
        addr       = t_addr;
        addr_valid = 1'b1;
        #1 chk1("cs_at_hs", mem_cs, 1'b0);
        @(negedge clk);
        chk1("ardy_after_hs", addr_ready, 1'b0);
        addr_valid = 1'b0;
        addr       = 12'($urandom);
        wvalid     = 1'b0;
        if (!hold) req = 1'b0;
        if (t_we) begin
            for (int d = 0; d < w_dly; d++) begin
                #1 chk1("cs_wdata_wait", mem_cs, 1'b0);
                chk1("busy_wdata", busy, 1'b1);
                @(negedge clk);
            end
            wvalid = 1'b1;
            wdata  = t_data;
            #1;
            chk1("wr_cs", mem_cs, 1'b1);
            chk1("wr_we", mem_we, 1'b1);
            chka("wr_addr", mem_addr, t_addr);
            chk("wr_data", mem_wdata, t_data);
            chk1("wr_no_rvalid", rvalid, 1'b0);
            ref_mem[t_addr] = t_data;
            rw[sel]++;
            @(negedge clk);
            wvalid = 1'b0;
            wdata  = rnd_line();
        end else begin
            chk1("rd_issue_cs", mem_cs, 1'b1);
            chk1("rd_issue_we", mem_we, 1'b0);
            chka("rd_issue_addr", mem_addr, t_addr);
            seen = 1'b0;
            for (int k = 1; k <= lat + 4 && !seen; k++) begin
                @(negedge clk);
                if (rvalid) begin
                    seen = 1'b1;
                    chkc("rd_latency", 16'(k), lat + 1);
                    chk("rdata", rdata, exp_line(t_addr));
                end else begin
                    chk1("cs_rd_wait", mem_cs, 1'b0);
                end
            end
            chk1("rvalid_seen", seen, 1'b1);
            rr[sel]++;
            @(negedge clk);
            chk1("rvalid_pulse", rvalid, 1'b0);
            chk("rdata_hold", rdata, exp_line(t_addr));
        end
        chk1("busy_idle", busy, 1'b0);
        chk1("cs_idle", mem_cs, 1'b0);
        chk_cnts("end");
    endtask

    // Grant, then drop req in ADDR with no address handshake.
    task automatic abort_txn();
        req = 1'b1;
        we  = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk1("abort_gnt", gnt, 1'b1);
        req = 1'b0;
        @(negedge clk);
        chk1("abort_ardy", addr_ready, 1'b1);
        #1 chk1("abort_cs", mem_cs, 1'b0);
        @(negedge clk);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_gnt_off", gnt, 1'b0);
        chk1("abort_cs_idle", mem_cs, 1'b0);
        chk_cnts("abort");
    endtask

    // addr_valid / wvalid pulsed in IDLE with no req.
    task automatic spur_idle();
        addr_valid = 1'b1;
        wvalid     = 1'b1;
        addr       = rand_addr();
        wdata      = rnd_line();
        #1 chk1("spur_idle_cs", mem_cs, 1'b0);
        chk1("spur_idle_ardy", addr_ready, 1'b0);
        @(negedge clk);
        chk1("spur_idle_busy", busy, 1'b0);
        chk1("spur_idle_gnt", gnt, 1'b0);
        addr_valid = 1'b0;
        wvalid     = 1'b0;
        @(negedge clk);
        chk1("spur_idle_busy2", busy, 1'b0);
        chk_cnts("spur_idle");
    endtask

    // Start a read, assert reset while waiting on SRAM data.
    task automatic reset_mid_read(input logic [AW-1:0] t_addr);
        int lat;
        lat = sel ? 3 : 1;
        req = 1'b1;
        we  = 1'b0;
        @(negedge clk);
        chk1("rmr_gnt", gnt, 1'b1);
        @(negedge clk);
        addr       = t_addr;
        addr_valid = 1'b1;
        @(negedge clk);
        addr_valid = 1'b0;
        req        = 1'b0;
        chk1("rmr_issue", mem_cs, 1'b1);
        @(negedge clk);
        chk1("rmr_wait_rvalid", rvalid, 1'b0);
        rst_n = 1'b0;
        #1 all_zero("rmr_rst");
        rw[0] = 0; rw[1] = 0; rr[0] = 0; rr[1] = 0;
        for (int i = 0; i < lat + 2; i++) begin
            @(negedge clk);
            chk1("rmr_rvalid_in_rst", rvalid, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk1("rmr_busy", busy, 1'b0);
        chk1("rmr_rvalid", rvalid, 1'b0);
        chk("rmr_rdata", rdata, '0);
        chk_cnts("rmr");
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            txn(1'($urandom_range(0, 1)), rand_addr(), rnd_line(),
                $urandom_range(0, 2), $urandom_range(0, 3),
                (i != n - 1) && ($urandom_range(0, 1) == 1),
                $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; mem_clr = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; addr_valid = 1'b0; wvalid = 1'b0; wdata = '0;
        rw[0] = 0; rw[1] = 0; rr[0] = 0; rr[1] = 0;
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        all_zero("reset_a");
        sel = 1'b1;
        #1 all_zero("reset_b");
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Instance A: RD_LAT=1
        txn(1'b0, 12'h0A5, '0, 0, 0, 1'b0, 1'b0);
        txn(1'b1, 12'hFFF, {32{8'hA5}}, 0, 5, 1'b0, 1'b0);
        txn(1'b0, 12'hFFF, '0, 1, 0, 1'b0, 1'b0);
        abort_txn();
        spur_idle();
        txn(1'b1, 12'h123, rnd_line(), 1, 2, 1'b0, 1'b1);
        txn(1'b0, 12'h123, '0, 0, 0, 1'b0, 1'b1);
        rand_phase(30);
        reset_mid_read(12'h0A5);
        txn(1'b0, 12'h0A5, '0, 0, 0, 1'b0, 1'b0);

        // Instance B: RD_LAT=3, 3-bit counters
        sel = 1'b1;
        @(negedge clk);
        txn(1'b0, 12'h0A1, '0, 0, 0, 1'b1, 1'b0);
        txn(1'b0, 12'hFFF, '0, 0, 0, 1'b1, 1'b0);
        txn(1'b0, 12'h0A5, '0, 0, 0, 1'b1, 1'b0);
        txn(1'b0, 12'h123, '0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8 && (rw[1] & 7) != 7; i++)
            txn(1'b1, rand_addr(), rnd_line(), 0, 0, 1'b0, 1'b0);
        chkc("wr_cnt_max", wr_cnt, 7);
        txn(1'b1, rand_addr(), rnd_line(), 0, 1, 1'b0, 1'b0);
        chkc("wr_cnt_wrap", wr_cnt, 0);
        abort_txn();
        spur_idle();
        reset_mid_read(rand_addr());
        txn(1'b0, rand_addr(), '0, 0, 0, 1'b0, 1'b0);
        rand_phase(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
